// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared types and Set-2 scancode constants for the PS/2 keyboard event path.
package ps2_pkg;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK, ST_PAUSE} ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Bytes the keyboard sends about itself rather than about keys.
  function automatic logic is_dev_resp(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction
endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-in / event-out bus of the keyboard controller.
interface ps2_kbd_ctrl_if #(parameter int DEPTH = 8) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_err;
  logic          rpt_suppress;
  logic          ev_valid;
  logic          ev_ready;
  logic [9:0]    ev_data;
  logic [CW-1:0] ev_count;
  logic          overflow;
  logic          ovf_clr;
  logic [7:0]    brk_cnt;

  modport slave (
    input  rx_valid, rx_data, rx_err, rpt_suppress, ev_ready, ovf_clr,
    output ev_valid, ev_data, ev_count, overflow, brk_cnt
  );

  modport master (
    output rx_valid, rx_data, rx_err, rpt_suppress, ev_ready, ovf_clr,
    input  ev_valid, ev_data, ev_count, overflow, brk_cnt
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// DEPTH-entry register FIFO of key events; push while full is accepted only with a pop.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  ps2_event_t                 din,
  output ps2_event_t                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  ps2_event_t    r_mem [DEPTH];
  logic          w_wr, w_rd;

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign w_wr  = push && (!full || pop);
  assign w_rd  = pop && !empty;
  assign dout  = r_mem[r_rd];
  assign count = r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Set-2 scancode sequencer: prefix FSM, abort timer, repeat filter and event FIFO.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic            clk,
  input  logic            resetn,
  ps2_kbd_ctrl_if.slave   bus
);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);
  localparam int CW = $clog2(DEPTH + 1);

  ps2_state_e    r_state;
  logic [2:0]    r_skip;
  logic [TW-1:0] r_timer;
  logic          r_lm_vld, r_lm_ext;
  logic [7:0]    r_lm_code;
  logic          r_ovf;
  logic [7:0]    r_brk_cnt;

  logic          w_byte, w_gen, w_lm_match, w_rpt_drop, w_emit;
  logic          w_push, w_pop, w_drop, w_full, w_empty;
  logic [7:0]    w_b;
  logic [TW-1:0] w_timer_inc;
  logic [CW-1:0] w_count;
  ps2_event_t    w_ev, w_head;

  assign w_b         = bus.rx_data;
  assign w_byte      = bus.rx_valid && !bus.rx_err;
  assign w_timer_inc = r_timer + 1'b1;

  always_comb begin
    w_gen = 1'b0;
    w_ev  = '0;
    if (w_byte) begin
      case (r_state)
        ST_IDLE:
          if (w_b != SC_EXT && w_b != SC_BRK && w_b != SC_PAUSE && !is_dev_resp(w_b)) begin
            w_gen = 1'b1;
            w_ev  = '{ext: 1'b0, brk: 1'b0, code: w_b};
          end
        ST_EXT:
          if (w_b != SC_EXT && w_b != SC_BRK) begin
            w_gen = 1'b1;
            w_ev  = '{ext: 1'b1, brk: 1'b0, code: w_b};
          end
        ST_BRK: begin
          w_gen = 1'b1;
          w_ev  = '{ext: 1'b0, brk: 1'b1, code: w_b};
        end
        ST_EXTBRK: begin
          w_gen = 1'b1;
          w_ev  = '{ext: 1'b1, brk: 1'b1, code: w_b};
        end
        ST_PAUSE:
          if (r_skip == 3'd1) begin
            w_gen = 1'b1;
            w_ev  = '{ext: 1'b1, brk: 1'b0, code: SC_PAUSE};
          end
        default: ;
      endcase
    end
  end

  assign w_lm_match = ({w_ev.ext, w_ev.code} == {r_lm_ext, r_lm_code});
  assign w_rpt_drop = w_gen && !w_ev.brk && bus.rpt_suppress && r_lm_vld && w_lm_match;
  assign w_emit     = w_gen && !w_rpt_drop;
  assign w_pop      = !w_empty && bus.ev_ready;
  assign w_push     = w_emit && (!w_full || w_pop);
  assign w_drop     = w_emit && w_full && !w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
      r_timer <= '0;
    end else if (bus.rx_err) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
      r_timer <= '0;
    end else if (bus.rx_valid) begin
      r_timer <= '0;
      case (r_state)
        ST_IDLE:
          if (w_b == SC_EXT)        r_state <= ST_EXT;
          else if (w_b == SC_BRK)   r_state <= ST_BRK;
          else if (w_b == SC_PAUSE) begin
            r_state <= ST_PAUSE;
            r_skip  <= PAUSE_SKIP;
          end
        ST_EXT:
          if (w_b == SC_BRK)        r_state <= ST_EXTBRK;
          else if (w_b != SC_EXT)   r_state <= ST_IDLE;
        ST_PAUSE: begin
          r_skip <= r_skip - 1'b1;
          if (r_skip == 3'd1) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && TIMEOUT_CYC != 0) begin
      // A stalled prefix sequence is abandoned without producing an event.
      if (w_timer_inc == TO_LIM) begin
        r_state <= ST_IDLE;
        r_skip  <= '0;
        r_timer <= '0;
      end else begin
        r_timer <= w_timer_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lm_vld  <= 1'b0;
      r_lm_ext  <= 1'b0;
      r_lm_code <= '0;
      r_ovf     <= 1'b0;
      r_brk_cnt <= '0;
    end else begin
      // Filter tracks emitted makes even when the FIFO has no room for them.
      if (w_emit && !w_ev.brk) begin
        r_lm_vld  <= 1'b1;
        r_lm_ext  <= w_ev.ext;
        r_lm_code <= w_ev.code;
      end else if (w_emit && w_ev.brk && w_lm_match) begin
        r_lm_vld  <= 1'b0;
      end
      if (w_drop)            r_ovf <= 1'b1;
      else if (bus.ovf_clr)  r_ovf <= 1'b0;
      if (w_push && w_ev.brk) r_brk_cnt <= r_brk_cnt + 1'b1;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_ev),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  assign bus.ev_valid = !w_empty;
  assign bus.ev_data  = w_head;
  assign bus.ev_count = w_count;
  assign bus.overflow = r_ovf;
  assign bus.brk_cnt  = r_brk_cnt;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed scancode sequences; expected events go to a queue checked by a monitor on handshake.
module tb_ps2_kbd_ctrl;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  ps2_kbd_ctrl_if #(.DEPTH(DEPTH)) bus ();

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  ps2_event_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
    ps2_event_t e;
    e = '{ext: ext, brk: brk, code: code};
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    ps2_event_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.ev_valid && bus.ev_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got %0h expected none", bus.ev_data);
        end else begin
          e = exp_q.pop_front();
          chk("event", 32'(bus.ev_data), 32'(e));
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_err = 1'b0;
    bus.rpt_suppress = 1'b0; bus.ev_ready = 1'b1; bus.ovf_clr = 1'b0;
    fork monitor(); join_none

    #12;
    chk("rst_ev_valid", 32'(bus.ev_valid), 32'd0);
    chk("rst_ev_data",  32'(bus.ev_data),  32'd0);
    chk("rst_ev_count", 32'(bus.ev_count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_brk_cnt",  32'(bus.brk_cnt),  32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);

    // plain make / break
    expect_ev(0, 0, 8'h1C); send(8'h1C);
    expect_ev(0, 1, 8'h1C); send(SC_BRK); send(8'h1C);
    idle(3);
    chk("brk_cnt_1", 32'(bus.brk_cnt), 32'd1);

    // extended make / break, doubled E0
    expect_ev(1, 0, 8'h75); send(SC_EXT); send(8'h75);
    expect_ev(1, 1, 8'h75); send(SC_EXT); send(SC_BRK); send(8'h75);
    expect_ev(1, 0, 8'h6B); send(SC_EXT); send(SC_EXT); send(8'h6B);
    idle(3);
    chk("brk_cnt_2", 32'(bus.brk_cnt), 32'd2);

    // pause sequence yields one event; device responses yield none
    expect_ev(1, 0, 8'hE1);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hFA); send(8'hAA); send(8'hEE); send(8'hFE); send(8'h00); send(8'hFF);
    drain("drain_pause");

    // typematic filter on, then off
    bus.rpt_suppress = 1'b1;
    expect_ev(0, 0, 8'h1C); expect_ev(0, 1, 8'h1C); expect_ev(0, 0, 8'h1C);
    send(8'h1C); send(8'h1C); send(8'h1C); send(SC_BRK); send(8'h1C); send(8'h1C);
    drain("drain_rpt_on");
    chk("brk_cnt_3", 32'(bus.brk_cnt), 32'd3);
    bus.rpt_suppress = 1'b0;
    expect_ev(0, 0, 8'h1C); expect_ev(0, 0, 8'h1C); expect_ev(0, 0, 8'h1C);
    expect_ev(0, 1, 8'h1C); expect_ev(0, 0, 8'h1C);
    send(8'h1C); send(8'h1C); send(8'h1C); send(SC_BRK); send(8'h1C); send(8'h1C);
    drain("drain_rpt_off");
    chk("brk_cnt_4", 32'(bus.brk_cnt), 32'd4);

    // timer: just under the limit keeps the prefix, past it aborts
    expect_ev(0, 1, 8'h1C); send(SC_BRK); idle(TO - 2); send(8'h1C);
    expect_ev(0, 0, 8'h1C); send(SC_BRK); idle(TO + 4); send(8'h1C);
    drain("drain_timeout");
    chk("brk_cnt_5", 32'(bus.brk_cnt), 32'd5);

    // rx_err alone and together with rx_valid
    expect_ev(0, 0, 8'h1C);
    send(SC_BRK);
    bus.rx_err = 1'b1; @(posedge clk); #1; bus.rx_err = 1'b0;
    send(8'h1C);
    expect_ev(0, 0, 8'h1C);
    bus.rx_err = 1'b1; send(SC_BRK); bus.rx_err = 1'b0;
    send(8'h1C);
    drain("drain_rx_err");

    // fill FIFO, drop the 9th event
    bus.ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_ev(0, 0, 8'(8'h15 + i));
      send(8'(8'h15 + i));
    end
    idle(2);
    chk("full_count",    32'(bus.ev_count), 32'd8);
    chk("full_overflow", 32'(bus.overflow), 32'd1);
    chk("full_head",     32'(bus.ev_data),  32'h015);
    // pop and push together while full
    bus.ev_ready = 1'b1;
    expect_ev(0, 0, 8'h2A);
    send(8'h2A);
    bus.ev_ready = 1'b0;
    idle(1);
    chk("popush_count", 32'(bus.ev_count), 32'd8);
    chk("popush_head",  32'(bus.ev_data),  32'h016);
    // clear racing a drop keeps overflow set
    bus.ovf_clr = 1'b1; send(8'h2B); bus.ovf_clr = 1'b0;
    chk("ovf_clr_vs_drop", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1; idle(1); bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    chk("count_after_clr", 32'(bus.ev_count), 32'd8);
    bus.ev_ready = 1'b1;
    drain("drain_full");
    chk("drained_count", 32'(bus.ev_count), 32'd0);

    // reset in the middle of a prefix with events queued
    bus.ev_ready = 1'b0;
    send(8'h15); send(8'h16); send(8'h17); send(SC_EXT);
    chk("pre_rst_count", 32'(bus.ev_count), 32'd3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_ev_valid", 32'(bus.ev_valid), 32'd0);
    chk("mid_rst_ev_count", 32'(bus.ev_count), 32'd0);
    chk("mid_rst_ev_data",  32'(bus.ev_data),  32'd0);
    chk("mid_rst_brk_cnt",  32'(bus.brk_cnt),  32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    idle(2);
    resetn = 1'b1;
    idle(1);
    bus.ev_ready = 1'b1;
    expect_ev(0, 0, 8'h75);
    send(8'h75);
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
